gate_resp_checker: RTL and testbench

- Response-side counterpart to our gate stimulus benches: a synthesizable checker that watches the vectors applied to a 2-input gate DUT and the DUT output.
- Compares each DUT output against a golden model for the selected gate function after a fixed pipeline latency, and counts vectors and mismatches.
- Captures the first failing vector and reports a run verdict.
- Sits beside any gate DUT on the board or in simulation, so benches need not hand-check `$monitor` output.

---
 rtl/gate_resp_checker.sv | 152 +++++++++++++++
 tb/tb_gate_resp_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_resp_checker.sv
// Response checker for a 2-input gate DUT: compares c against a golden gate model
// after LAT cycles, counts vectors and mismatches, captures the first failure.
module gate_resp_checker #(
  parameter int N_VEC = 4,
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] fail_idx,
  output logic [1:0]       fail_ab,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic             fail_seen;
  logic             pass_q;
  logic             accept;
  logic             exp_now;
  logic             last_acc;
  logic             cmp_vld;
  logic             cmp_exp;
  logic [CNT_W-1:0] cmp_idx;
  logic [1:0]       cmp_ab;
  logic             mismatch;
  logic             last_cmp;

  function automatic logic gate_f(input logic [1:0] f, input logic x, input logic y);
    case (f)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Handshake: a vector is accepted on any RUN cycle with vld=1; there is no
  // back-pressure, the checker always keeps up with the DUT stimulus.
  assign accept   = (state == S_RUN) && vld;
  assign exp_now  = gate_f(op_q, a, b);
  assign last_acc = accept && (vec_cnt == CNT_W'(N_VEC - 1));
  assign mismatch = cmp_vld && (c != cmp_exp);
  assign last_cmp = cmp_vld && (cmp_idx == CNT_W'(N_VEC - 1));

  generate
    if (LAT == 0) begin : g_comb
      assign cmp_vld = accept;
      assign cmp_exp = exp_now;
      assign cmp_idx = vec_cnt;
      assign cmp_ab  = {a, b};
    end else begin : g_dl
      // Payload travels alongside a valid bit so vld gaps produce no compare.
      logic             dl_vld [LAT];
      logic             dl_exp [LAT];
      logic [CNT_W-1:0] dl_idx [LAT];
      logic [1:0]       dl_ab  [LAT];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) dl_vld[i] <= 1'b0;
        end else begin
          dl_vld[0] <= accept;
          for (int i = 1; i < LAT; i++) dl_vld[i] <= dl_vld[i-1];
        end
        dl_exp[0] <= exp_now;
        dl_idx[0] <= vec_cnt;
        dl_ab[0]  <= {a, b};
        for (int i = 1; i < LAT; i++) begin
          dl_exp[i] <= dl_exp[i-1];
          dl_idx[i] <= dl_idx[i-1];
          dl_ab[i]  <= dl_ab[i-1];
        end
      end

      assign cmp_vld = dl_vld[LAT-1];
      assign cmp_exp = dl_exp[LAT-1];
      assign cmp_idx = dl_idx[LAT-1];
      assign cmp_ab  = dl_ab[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= 2'b00;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      fail_idx  <= '0;
      fail_ab   <= 2'b00;
      fail_seen <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q      <= op;
            vec_cnt   <= '0;
            err_cnt   <= '0;
            fail_idx  <= '0;
            fail_ab   <= 2'b00;
            fail_seen <= 1'b0;
            pass_q    <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (last_acc) state <= (LAT == 0) ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          if (last_cmp) state <= S_DONE;
        end
        default: begin
          pass_q <= (err_cnt == '0);
          state  <= S_IDLE;
        end
      endcase
      if (accept) vec_cnt <= vec_cnt + 1'b1;
      if (mismatch) begin
        err_cnt <= err_cnt + 1'b1;
        if (!fail_seen) begin
          fail_seen <= 1'b1;
          fail_idx  <= cmp_idx;
          fail_ab   <= cmp_ab;
        end
      end
    end
  end

  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  // err_cnt is final by the DONE cycle, so the verdict is visible with done.
  assign pass      = done ? (err_cnt == '0) : pass_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: three instances (LAT 0, 1, 3) watch a modelled gate
// DUT; run results are predicted from the vector list, op and injected errors.
module tb_gate_resp_checker;

  logic clk = 1'b0;
  logic rst_n, start, vld, a, b;
  logic [1:0] op;
  logic [2:0] c_w, busy_w, done_w, pass_w;
  logic [2:0][7:0] vec_w, err_w, fidx_w;
  logic [2:0][1:0] fab_w, st_w;

  always #5 clk = ~clk;

  gate_resp_checker #(.N_VEC(4), .LAT(0), .CNT_W(8)) u_l0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .vld(vld), .a(a), .b(b),
    .c(c_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .vec_cnt(vec_w[0]), .err_cnt(err_w[0]), .fail_idx(fidx_w[0]),
    .fail_ab(fab_w[0]), .dbg_state(st_w[0]));

  gate_resp_checker #(.N_VEC(4), .LAT(1), .CNT_W(8)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .vld(vld), .a(a), .b(b),
    .c(c_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .vec_cnt(vec_w[1]), .err_cnt(err_w[1]), .fail_idx(fidx_w[1]),
    .fail_ab(fab_w[1]), .dbg_state(st_w[1]));

  gate_resp_checker #(.N_VEC(4), .LAT(3), .CNT_W(8)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .vld(vld), .a(a), .b(b),
    .c(c_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .vec_cnt(vec_w[2]), .err_cnt(err_w[2]), .fail_idx(fidx_w[2]),
    .fail_ab(fab_w[2]), .dbg_state(st_w[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic hist [4];
  logic [1:0] model_op;
  logic [1:0] vec_ab [4];
  int gap [4];
  logic flip [4];
  int done_cnt [3];
  int done_at [3];
  int busy_cnt [3];
  logic pass_at_done [3];

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic gate_ref(input logic [1:0] f, input logic [1:0] ab);
    case (f)
      2'b00:   return ab[1] & ab[0];
      2'b01:   return ab[1] | ab[0];
      2'b10:   return ab[1] ^ ab[0];
      default: return ~(ab[1] & ab[0]);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, model the gate DUT's delayed output, then observe.
  task automatic step(input logic v, input logic real_vec, input logic [1:0] ab, input logic fl);
    vld = v;
    a = ab[1];
    b = ab[0];
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = real_vec ? (gate_ref(model_op, ab) ^ fl) : 1'($urandom_range(0, 1));
    c_w = {hist[3], hist[1], hist[0]};
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (done_w[k]) begin
        done_cnt[k]++;
        done_at[k] = cyc;
        pass_at_done[k] = pass_w[k];
      end
      if (busy_w[k]) busy_cnt[k]++;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 3; k++) begin
      done_cnt[k] = 0;
      done_at[k] = -1;
      busy_cnt[k] = 0;
      pass_at_done[k] = 1'bx;
    end
  endtask

  task automatic do_run(input logic [1:0] run_op, input bit toggle_op, input int pre_vld);
    int start_cyc, t_last, n_fl, first_fl, lat;
    clear_obs();
    for (int i = 0; i < pre_vld; i++) begin
      op = 2'($urandom_range(0, 3));
      step(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
    end
    model_op = run_op;
    op = run_op;
    start = 1'b1;
    start_cyc = cyc;
    step(pre_vld > 0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
    start = 1'b0;
    t_last = cyc;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        if (toggle_op) op = 2'($urandom_range(0, 3));
        idle_step();
      end
      if (toggle_op) op = ~run_op;
      t_last = cyc;
      step(1'b1, 1'b1, vec_ab[i], flip[i]);
    end
    for (int g = 0; g < 10 && cyc < t_last + 5; g++) idle_step();

    n_fl = 0;
    first_fl = -1;
    for (int i = 0; i < 4; i++) begin
      if (flip[i]) begin
        if (first_fl < 0) first_fl = i;
        n_fl++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      lat = lat_of(k);
      check_eq($sformatf("L%0d done_count", lat), done_cnt[k], 1);
      check_eq($sformatf("L%0d done_cycle", lat), done_at[k], t_last + lat + 1);
      check_eq($sformatf("L%0d pass_at_done", lat), {31'd0, pass_at_done[k]}, {31'd0, n_fl == 0});
      check_eq($sformatf("L%0d pass_held", lat), {31'd0, pass_w[k]}, {31'd0, n_fl == 0});
      check_eq($sformatf("L%0d vec_cnt", lat), vec_w[k], 4);
      check_eq($sformatf("L%0d err_cnt", lat), err_w[k], n_fl);
      check_eq($sformatf("L%0d fail_idx", lat), fidx_w[k], (n_fl > 0) ? first_fl : 0);
      check_eq($sformatf("L%0d fail_ab", lat), fab_w[k], (n_fl > 0) ? vec_ab[first_fl] : 2'b00);
      check_eq($sformatf("L%0d busy_cycles", lat), busy_cnt[k], t_last + lat - start_cyc);
    end
  endtask

  task automatic set_vecs(input logic [7:0] abs, input logic [3:0] fl, input int g1);
    for (int i = 0; i < 4; i++) begin
      vec_ab[i] = abs[7-2*i -: 2];
      flip[i] = fl[3-i];
      gap[i] = (i == 0) ? 0 : g1;
    end
  endtask

  task automatic check_zeroed(input string what);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s L%0d busy", what, lat_of(k)), {31'd0, busy_w[k]}, 0);
      check_eq($sformatf("%s L%0d done", what, lat_of(k)), {31'd0, done_w[k]}, 0);
      check_eq($sformatf("%s L%0d pass", what, lat_of(k)), {31'd0, pass_w[k]}, 0);
      check_eq($sformatf("%s L%0d vec_cnt", what, lat_of(k)), vec_w[k], 0);
      check_eq($sformatf("%s L%0d err_cnt", what, lat_of(k)), err_w[k], 0);
      check_eq($sformatf("%s L%0d fail_idx", what, lat_of(k)), fidx_w[k], 0);
      check_eq($sformatf("%s L%0d fail_ab", what, lat_of(k)), fab_w[k], 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    vld = 1'b0;
    op = 2'b00;
    a = 1'b0;
    b = 1'b0;
    model_op = 2'b00;
    for (int i = 0; i < 4; i++) hist[i] = 1'b0;
    c_w = 3'b000;
    clear_obs();

    repeat (3) idle_step();
    check_zeroed("reset");
    rst_n = 1'b1;
    idle_step();

    // AND, clean, back-to-back
    set_vecs(8'b00_01_10_11, 4'b0000, 0);
    do_run(2'b00, 1'b0, 0);
    // AND, error at index 2 only, then at 2 and 3
    set_vecs(8'b00_01_10_11, 4'b0010, 0);
    do_run(2'b00, 1'b0, 0);
    set_vecs(8'b00_01_10_11, 4'b0011, 0);
    do_run(2'b00, 1'b0, 0);
    // XOR with two-cycle vld gaps
    set_vecs(8'b00_11_01_10, 4'b0000, 2);
    do_run(2'b10, 1'b0, 0);
    // op toggling during the run and vld activity before start
    set_vecs(8'b11_10_01_00, 4'b0000, 1);
    do_run(2'b01, 1'b1, 3);
    // NAND, back-to-back
    set_vecs(8'b00_01_10_11, 4'b0000, 0);
    do_run(2'b11, 1'b0, 0);

    // Reset after 2 of 4 vectors, with an error still in flight
    clear_obs();
    model_op = 2'b00;
    op = 2'b00;
    start = 1'b1;
    idle_step();
    start = 1'b0;
    step(1'b1, 1'b1, 2'b11, 1'b0);
    step(1'b1, 1'b1, 2'b01, 1'b1);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 2'b10, 1'b0);
    rst_n = 1'b1;
    check_zeroed("mid_reset");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("post_reset L%0d done_count", lat_of(k)), done_cnt[k], 0);
      check_eq($sformatf("post_reset L%0d vec_cnt", lat_of(k)), vec_w[k], 0);
      check_eq($sformatf("post_reset L%0d err_cnt", lat_of(k)), err_w[k], 0);
    end
    set_vecs(8'b00_01_10_11, 4'b0000, 0);
    do_run(2'b00, 1'b0, 0);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) begin
        vec_ab[i] = 2'($urandom_range(0, 3));
        gap[i] = $urandom_range(0, 2);
        flip[i] = ($urandom_range(0, 3) == 0);
      end
      do_run(2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
